fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: single-issue instruction fetch with an IF/ID pipeline register.
//
// Issues one imem request at a time, captures the returned word into IF/ID,
// and handles decode stalls (hold buffer) and execute-stage redirects
// (squashing any in-flight request).
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   stall                 decode hazard: hold IF/ID and pc
//   redirect, redirect_pc taken branch/jump and its target
//   imem_req, imem_addr   one-cycle fetch strobe and address
//   imem_rdy, imem_data   fetch response, one per accepted request
//   if_id_valid/pc/inst   IF/ID register contents presented to decode
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_data,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst
);

    typedef enum logic [1:0] {
        S_REQ,   // strobe imem_req with imem_addr = pc
        S_WAIT,  // request accepted, response pending
        S_HOLD,  // response parked in hold_buf until stall drops
        S_DROP   // response still owed by a squashed request
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] hold_buf;

    // An instruction enters IF/ID only when decode is free and no redirect
    // is squashing this cycle's fetch.
    logic        load;
    logic [31:0] load_inst;

    always_comb begin
        load      = 1'b0;
        load_inst = imem_data;
        if (!redirect && !stall) begin
            if (state == S_WAIT && imem_rdy) begin
                load      = 1'b1;
                load_inst = imem_data;
            end else if (state == S_HOLD) begin
                load      = 1'b1;
                load_inst = hold_buf;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            hold_buf    <= 32'h0;
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'h0;
            if_id_inst  <= NOP_INST;
        end else begin
            // IF/ID: load, else bubble (redirect or free decode), else hold.
            if (load) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= pc;
                if_id_inst  <= load_inst;
            end else if (redirect || !stall) begin
                if_id_valid <= 1'b0;
                if_id_inst  <= NOP_INST;
            end

            // pc advances only once its instruction reaches IF/ID.
            if (redirect)
                pc <= {redirect_pc[31:2], 2'b00};
            else if (load)
                pc <= pc + 32'd4;

            case (state)
                S_REQ:  state <= redirect ? S_REQ : S_WAIT;
                S_WAIT: begin
                    if (redirect) begin
                        // Data arriving now is simply discarded; otherwise
                        // the response is still owed and must be drained.
                        state <= imem_rdy ? S_REQ : S_DROP;
                    end else if (imem_rdy) begin
                        if (stall) begin
                            hold_buf <= imem_data;
                            state    <= S_HOLD;
                        end else begin
                            state    <= S_REQ;
                        end
                    end
                end
                S_HOLD: if (redirect || !stall) state <= S_REQ;
                // A further redirect here only retargets pc; the owed
                // response is still the one that ends the drain, so leaving
                // on imem_rdy regardless avoids waiting forever.
                S_DROP: if (imem_rdy) state <= S_REQ;
                default: state <= S_REQ;
            endcase
        end
    end

    // state is forced to S_REQ during reset, so the strobe is masked there.
    assign imem_req  = (state == S_REQ) && !reset;
    assign imem_addr = pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random stall/redirect
// traffic against a transaction-level model. The driver acts as instruction
// memory and predicts which fetches reach IF/ID; the monitor compares IF/ID
// after every edge.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0100_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_rdy = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_data(imem_data), .if_id_valid(if_id_valid),
        .if_id_pc(if_id_pc), .if_id_inst(if_id_inst)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_t;

    fetch_t sb[$];     // instructions expected to enter IF/ID at the next edge
    fetch_t held[$];   // fetched, waiting for decode to accept it
    logic [31:0] mem [logic [31:0]];
    int total = 0;
    int bad = 0;

    // memory responder state
    logic        out_busy = 1'b0;
    logic        out_sq = 1'b0;
    logic [31:0] out_addr = 32'h0;
    int          out_cnt = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] exp_pc = RESET_PC;   // next address the program should fetch

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    // One cycle, entered at a negedge: answer memory, drive inputs, predict.
    task automatic step(input logic s, input logic r, input logic [31:0] rpc,
                        input logic late = 1'b0);
        logic        rdy_now;
        logic        rsp_sq;
        logic [31:0] rsp_data;
        fetch_t      f;
        rdy_now  = 1'b0;
        rsp_sq   = 1'b0;
        rsp_data = $urandom;
        if (out_busy) begin
            out_cnt--;
            if (out_cnt == 0) begin
                rdy_now  = 1'b1;
                rsp_sq   = out_sq;
                rsp_data = rd(out_addr);
                out_busy = 1'b0;
            end
        end
        if (imem_req) begin
            chk("req_while_pending", {31'b0, out_busy || rdy_now}, 32'h0);
            chk("req_addr", imem_addr, exp_pc);
            out_busy = 1'b1;
            out_sq   = 1'b0;
            out_addr = imem_addr;
            out_cnt  = int'($urandom_range(lat_max, lat_min));
        end
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        imem_rdy    = rdy_now || late;
        imem_data   = rsp_data;
        // reference: what this edge does to the instruction stream
        if (r) begin
            held.delete();
            if (out_busy) out_sq = 1'b1;
            exp_pc = {rpc[31:2], 2'b00};
        end else begin
            if (rdy_now && !rsp_sq) begin
                f.pc   = exp_pc;
                f.inst = rd(exp_pc);
                held.push_back(f);
            end
            if (held.size() != 0 && !s) begin
                sb.push_back(held.pop_front());
                exp_pc = exp_pc + 32'd4;
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset(input int cyc);
        reset    = 1'b1;
        stall    = 1'b0;
        redirect = 1'b0;
        imem_rdy = 1'b0;
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rst_inst", if_id_inst, NOP_INST);
        chk("rst_pc", if_id_pc, 32'h0);
        held.delete();
        sb.delete();
        out_busy = 1'b0;
        exp_pc   = RESET_PC;
        repeat (cyc) @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    // Monitor: after each edge, IF/ID must show the predicted instruction,
    // a bubble, or its previous contents when stalled.
    initial begin
        logic        e_s, e_r, e_rst;
        logic        p_v;
        logic [31:0] p_pc, p_inst;
        fetch_t      f;
        p_v = 1'b0; p_pc = 32'h0; p_inst = NOP_INST;
        forever begin
            @(posedge clock);
            e_s = stall; e_r = redirect; e_rst = reset;
            #1;
            if (!e_rst && !reset) begin
                if (e_r) begin
                    chk("redir_valid", {31'b0, if_id_valid}, 32'h0);
                    chk("redir_inst", if_id_inst, NOP_INST);
                    chk("redir_pc", if_id_pc, p_pc);
                end else if (e_s) begin
                    chk("stall_valid", {31'b0, if_id_valid}, {31'b0, p_v});
                    chk("stall_inst", if_id_inst, p_inst);
                    chk("stall_pc", if_id_pc, p_pc);
                end else begin
                    chk("ifid_valid", {31'b0, if_id_valid}, {31'b0, sb.size() != 0});
                    if (sb.size() != 0) begin
                        f = sb.pop_front();
                        chk("ifid_pc", if_id_pc, f.pc);
                        chk("ifid_inst", if_id_inst, f.inst);
                    end else begin
                        chk("bubble_inst", if_id_inst, NOP_INST);
                        chk("bubble_pc", if_id_pc, p_pc);
                    end
                end
            end
            p_v = if_id_valid; p_pc = if_id_pc; p_inst = if_id_inst;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        mem[32'h0100_0000] = 32'h0050_0093;
        mem[32'h0100_0004] = 32'h00A0_0113;
        mem[32'h0100_0008] = 32'h0020_81B3;
        @(negedge clock);
        do_reset(2);

        // back-to-back fetches, memory answers in the WAIT cycle
        chk("s1_req0", {31'b0, imem_req}, 32'h1);
        chk("s1_addr0", imem_addr, RESET_PC);
        step(0, 0, 0);
        chk("s1_req1", {31'b0, imem_req}, 32'h0);
        step(0, 0, 0);
        chk("s1_valid_a", {31'b0, if_id_valid}, 32'h1);
        chk("s1_pc_a", if_id_pc, 32'h0100_0000);
        chk("s1_inst_a", if_id_inst, 32'h0050_0093);
        chk("s1_req2", {31'b0, imem_req}, 32'h1);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("s1_pc_b", if_id_pc, 32'h0100_0004);
        chk("s1_inst_b", if_id_inst, 32'h00A0_0113);

        // three stalled cycles while the response lands in the hold buffer
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("s2_hold_inst", if_id_inst, 32'h00A0_0113);
        chk("s2_hold_valid", {31'b0, if_id_valid}, 32'h1);
        chk("s2_no_req", {31'b0, imem_req}, 32'h0);
        step(0, 0, 0);
        chk("s2_inst", if_id_inst, 32'h0020_81B3);
        chk("s2_pc", if_id_pc, 32'h0100_0008);
        chk("s2_next_addr", imem_addr, 32'h0100_000C);

        // redirect in WAIT, squashed response arrives two cycles later
        lat_min = 3; lat_max = 3;
        step(0, 0, 0);
        step(0, 1, 32'h0100_0041);
        chk("s3_valid", {31'b0, if_id_valid}, 32'h0);
        chk("s3_inst", if_id_inst, NOP_INST);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("s3_req", {31'b0, imem_req}, 32'h1);
        chk("s3_addr", imem_addr, 32'h0100_0040);

        // redirect and stall together
        lat_min = 1; lat_max = 1;
        step(0, 0, 0);
        step(1, 1, 32'h0100_0100);
        chk("s4_valid", {31'b0, if_id_valid}, 32'h0);
        chk("s4_addr", imem_addr, 32'h0100_0100);

        // pc wrap
        step(0, 0, 0);
        step(0, 1, 32'hFFFF_FFFC);
        chk("s5_addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("s5_pc", if_id_pc, 32'hFFFF_FFFC);
        chk("s5_next_addr", imem_addr, 32'h0000_0000);

        // random traffic; redirects are raised outside request cycles so the
        // responder's single-outstanding bookkeeping stays exact
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 600; i++) begin
            logic s, r;
            s = ($urandom_range(99, 0) < 30);
            r = !imem_req && ($urandom_range(99, 0) < 8);
            step(s, r, $urandom);
        end

        // reset while a response is pending, late imem_rdy after release
        lat_min = 2; lat_max = 2;
        n = 0;
        while (!imem_req && n < 20) begin
            step(0, 0, 0);
            n++;
        end
        chk("s6_reach_req", {31'b0, imem_req}, 32'h1);
        step(0, 0, 0);
        do_reset(2);
        lat_min = 1; lat_max = 1;
        chk("s6_req", {31'b0, imem_req}, 32'h1);
        chk("s6_addr", imem_addr, RESET_PC);
        step(0, 0, 0, 1'b1);
        chk("s6_no_valid", {31'b0, if_id_valid}, 32'h0);
        step(0, 0, 0);
        chk("s6_valid", {31'b0, if_id_valid}, 32'h1);
        chk("s6_pc", if_id_pc, RESET_PC);
        chk("s6_inst", if_id_inst, 32'h0050_0093);

        repeat (4) step(0, 0, 0);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
